inst_cache: RTL and testbench

- Direct-mapped, read-only instruction cache. It is the responder on the pre-IF request interface (valid/uncache/tag/index/offset, returning addr_ok), and it returns data to IF via data_ok/rdata.
- Misses and uncached fetches go to the bus bridge through a read-request/return channel.
- Geometry: 256 lines × 16 bytes, one tag per line, physically tagged.

---
 rtl/inst_cache_if.sv | 33 +++
 rtl/inst_cache.sv | 127 ++++++++++++
 tb/tb_inst_cache.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_if.sv
// Request, response and bus-refill signals of the instruction cache.
// slave is the cache view; master is the pre-IF / bus-bridge view.
interface inst_cache_if #(
  parameter int unsigned TAG_W    = 20,
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned OFFSET_W = 4
);
  logic                valid;
  logic                uncache;
  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  logic                addr_ok;
  logic                data_ok;
  logic [31:0]         rdata;
  logic                rd_req;
  logic [2:0]          rd_type;
  logic [31:0]         rd_addr;
  logic                rd_rdy;
  logic                ret_valid;
  logic                ret_last;
  logic [31:0]         ret_data;

  modport slave (
    input  valid, uncache, tag, index, offset, rd_rdy, ret_valid, ret_last, ret_data,
    output addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr
  );

  modport master (
    output valid, uncache, tag, index, offset, rd_rdy, ret_valid, ret_last, ret_data,
    input  addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, blocking line refill
// on miss, single-word bus read for uncached fetches.
module inst_cache #(
  parameter int unsigned TAG_W    = 20,
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned OFFSET_W = 4
) (
  input  logic        clk,
  input  logic        resetn,
  inst_cache_if.slave bus
);
  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned WSEL_W = OFFSET_W - 2;
  localparam int unsigned WORDS  = 1 << WSEL_W;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL} state_e;

  state_e              state_q;
  logic                req_unc_q;
  logic [TAG_W-1:0]    req_tag_q;
  logic [INDEX_W-1:0]  req_idx_q;
  logic [OFFSET_W-1:0] req_off_q;
  logic [WSEL_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   crit_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [LINES-1:0]    vld_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES][WORDS];

  logic                hit_c;
  logic                accept_c;
  logic                beat_c;
  logic                fill_done_c;
  logic                data_ok_c;
  logic [WSEL_W-1:0]   word_sel_c;
  logic [DATA_W-1:0]   rdata_new_c;

  always_comb begin
    word_sel_c  = req_off_q[OFFSET_W-1:2];
    hit_c       = (state_q == S_LOOKUP) && !req_unc_q && vld_q[req_idx_q]
                  && (tag_q[req_idx_q] == req_tag_q);
    beat_c      = (state_q == S_REFILL) && bus.ret_valid;
    fill_done_c = beat_c && bus.ret_last;
    data_ok_c   = hit_c || fill_done_c;
    accept_c    = resetn && bus.valid && ((state_q == S_IDLE) || hit_c);
    // Critical word may be the beat on the bus right now, so bypass the buffer.
    if (hit_c) begin
      rdata_new_c = data_q[req_idx_q][word_sel_c];
    end else if (req_unc_q || (cnt_q == word_sel_c)) begin
      rdata_new_c = bus.ret_data;
    end else begin
      rdata_new_c = crit_q;
    end
  end

  assign bus.addr_ok = accept_c;
  assign bus.data_ok = data_ok_c;
  assign bus.rdata   = data_ok_c ? rdata_new_c : rdata_q;
  assign bus.rd_req  = (state_q == S_MISS);
  assign bus.rd_type = (state_q != S_MISS) ? 3'b000 : (req_unc_q ? 3'b010 : 3'b100);
  assign bus.rd_addr = (state_q != S_MISS) ? 32'h0
                     : req_unc_q ? {req_tag_q, req_idx_q, req_off_q}
                                 : {req_tag_q, req_idx_q, OFFSET_W'(0)};

  // Tag and data arrays carry no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (beat_c && !req_unc_q) begin
      data_q[req_idx_q][cnt_q] <= bus.ret_data;
    end
    if (fill_done_c && !req_unc_q) begin
      tag_q[req_idx_q] <= req_tag_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      req_unc_q <= 1'b0;
      req_tag_q <= '0;
      req_idx_q <= '0;
      req_off_q <= '0;
      cnt_q     <= '0;
      crit_q    <= '0;
      rdata_q   <= '0;
      vld_q     <= '0;
    end else begin
      if (accept_c) begin
        req_unc_q <= bus.uncache;
        req_tag_q <= bus.tag;
        req_idx_q <= bus.index;
        req_off_q <= bus.offset;
      end
      if (data_ok_c) begin
        rdata_q <= rdata_new_c;
      end
      case (state_q)
        S_IDLE: begin
          if (accept_c) state_q <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (hit_c) state_q <= accept_c ? S_LOOKUP : S_IDLE;
          else       state_q <= S_MISS;
        end
        S_MISS: begin
          if (bus.rd_rdy) begin
            state_q <= S_REFILL;
            cnt_q   <= '0;
          end
        end
        S_REFILL: begin
          if (beat_c) begin
            if (!req_unc_q) begin
              cnt_q <= cnt_q + WSEL_W'(1);
              if (cnt_q == word_sel_c) crit_q <= bus.ret_data;
            end
            if (bus.ret_last) begin
              if (!req_unc_q) vld_q[req_idx_q] <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_cache.sv
// Bench for inst_cache: transaction-level cache model plus a randomized bus
// responder, checked on every negedge, with directed scenarios pinned by literals.
module tb_inst_cache;
  logic clk;
  logic resetn;

  inst_cache_if #(.TAG_W(20), .INDEX_W(8), .OFFSET_W(4)) bif();
  inst_cache #(.TAG_W(20), .INDEX_W(8), .OFFSET_W(4)) dut (
    .clk(clk), .resetn(resetn), .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out (cycle %0d)", nm, cyc);
  endtask

  // Backing memory: preloaded words, hashed values elsewhere.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9e3779b1) ^ 32'h5a5a1234;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          acc;
    bit          miss;
    logic [31:0] data;
    logic [31:0] baddr;
    logic [2:0]  btype;
  } exp_t;

  exp_t        pq[$];
  bit [255:0]  mvalid;
  logic [19:0] mtag [256];
  bit          granted = 0;
  logic [31:0] last_rdata = '0;
  logic [31:0] rlog[$];
  int          dcyc[$];

  always @(negedge clk) begin : cmp
    bit          head_v, head_miss, exp_aok, exp_dok, exp_req;
    exp_t        h, n;
    logic [31:0] full;
    cyc++;
    if (!resetn) begin
      chk("rst_addr_ok", 32'(bif.addr_ok), 32'd0);
      chk("rst_data_ok", 32'(bif.data_ok), 32'd0);
      chk("rst_rd_req",  32'(bif.rd_req),  32'd0);
      chk("rst_rdata",   bif.rdata,        32'd0);
      pq.delete();
      mvalid     = '0;
      granted    = 0;
      last_rdata = '0;
    end else begin
      head_v = (pq.size() > 0);
      if (head_v) h = pq[0];
      head_miss = head_v && h.miss;
      exp_aok   = bif.valid && !head_miss;
      if (!head_v)      exp_dok = 0;
      else if (!h.miss) exp_dok = (cyc == h.acc + 1);
      else              exp_dok = granted && bif.ret_valid && bif.ret_last;
      exp_req = head_miss && !granted && (cyc >= h.acc + 2);

      chk("addr_ok", 32'(bif.addr_ok), 32'(exp_aok));
      chk("data_ok", 32'(bif.data_ok), 32'(exp_dok));
      chk("rd_req",  32'(bif.rd_req),  32'(exp_req));
      if (exp_req) begin
        chk("rd_type", 32'(bif.rd_type), 32'(h.btype));
        chk("rd_addr", bif.rd_addr, h.baddr);
      end
      if (exp_dok) begin
        chk("rdata", bif.rdata, h.data);
        last_rdata = h.data;
        rlog.push_back(bif.rdata);
        dcyc.push_back(cyc);
        void'(pq.pop_front());
        if (h.miss) granted = 0;
      end else begin
        chk("rdata_hold", bif.rdata, last_rdata);
      end
      if (exp_req && bif.rd_rdy) granted = 1;
      if (bif.valid && exp_aok) begin
        full    = {bif.tag, bif.index, bif.offset};
        n.acc   = cyc;
        n.miss  = bif.uncache || !(mvalid[bif.index] && mtag[bif.index] == bif.tag);
        n.data  = mem_word(full);
        n.btype = bif.uncache ? 3'b010 : 3'b100;
        n.baddr = bif.uncache ? full : {full[31:4], 4'h0};
        if (n.miss && !bif.uncache) begin
          mvalid[bif.index] = 1'b1;
          mtag[bif.index]   = bif.tag;
        end
        pq.push_back(n);
      end
    end
  end

  // ---------------- bus bridge responder ----------------
  int          wait_cnt = 0, bl = 0, bi = 0, stall_n = 0, req_cycles = 0;
  int          burst_beats = 0, grants = 0;
  bit          rand_stall = 0, real_beat = 0;
  logic [31:0] baddr = '0, last_gaddr = '0;
  logic [2:0]  last_gtype = '0;

  initial begin : drv
    bit          g, b, seen;
    logic [2:0]  gt;
    logic [31:0] ga;
    bif.rd_rdy = 0; bif.ret_valid = 0; bif.ret_last = 0; bif.ret_data = '0;
    forever begin
      @(negedge clk);
      g    = resetn && bif.rd_req && bif.rd_rdy;
      seen = resetn && bif.rd_req;
      b    = bif.ret_valid && real_beat;
      gt   = bif.rd_type;
      ga   = bif.rd_addr;
      @(posedge clk); #1;
      if (b) begin bi++; bl--; burst_beats++; end
      if (g) begin
        bl = (gt == 3'b010) ? 1 : 4;
        bi = 0; baddr = ga; burst_beats = 0;
        req_cycles = wait_cnt + 1; wait_cnt = 0;
        last_gaddr = ga; last_gtype = gt; grants++;
        if (rand_stall) stall_n = $urandom_range(0, 3);
      end else if (seen) begin
        wait_cnt++;
      end
      if (!resetn) wait_cnt = 0;
      if (bl > 0) begin
        bif.rd_rdy = 0;
        if ($urandom_range(0, 3) != 0) begin
          real_beat = 1; bif.ret_valid = 1; bif.ret_last = (bl == 1);
          bif.ret_data = mem_word(baddr + 32'(4 * bi));
        end else begin
          real_beat = 0; bif.ret_valid = 0; bif.ret_last = 0; bif.ret_data = $urandom;
        end
      end else begin
        bif.rd_rdy = (wait_cnt >= stall_n);
        real_beat  = 0;
        // Stray beats outside a refill must be ignored by the cache.
        bif.ret_valid = ($urandom_range(0, 9) == 0);
        bif.ret_last  = bif.ret_valid && ($urandom_range(0, 1) == 1);
        bif.ret_data  = $urandom;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit u, input logic [19:0] t, input logic [7:0] i, input logic [3:0] o);
    int n;
    bif.valid = 1; bif.uncache = u; bif.tag = t; bif.index = i; bif.offset = o;
    n = 0;
    forever begin
      @(negedge clk);
      if (bif.addr_ok) break;
      n++;
      if (n > 300) begin fail("issue_accept"); break; end
    end
    @(posedge clk); #1;
    bif.valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pq.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin fail("drain"); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int g0, k;
    bit u;
    logic [19:0] t;
    logic [7:0]  ix;
    logic [3:0]  o;
    resetn = 0;
    bif.valid = 0; bif.uncache = 0; bif.tag = '0; bif.index = '0; bif.offset = '0;
    mem[32'h1fc00000] = 32'h11; mem[32'h1fc00004] = 32'h22;
    mem[32'h1fc00008] = 32'h33; mem[32'h1fc0000c] = 32'h44;
    mem[32'h1fc00018] = 32'hdeadbeef;
    for (int j = 0; j < 4; j++) mem[32'h00400000 + 32'(4 * j)] = 32'ha0a00000 + 32'(j);

    repeat (2) @(posedge clk);
    #1 bif.valid = 1;
    #1 chk("rst_addr_ok_lit", 32'(bif.addr_ok), 32'd0);
    bif.valid = 0;
    @(posedge clk); #1 resetn = 1;
    @(posedge clk); #1;

    // Cold miss
    g0 = grants;
    issue(0, 20'h1fc00, 8'h00, 4'h4); drain();
    chk("cold_grants", 32'(grants - g0), 32'd1);
    chk("cold_rd_addr", last_gaddr, 32'h1fc00000);
    chk("cold_rd_type", 32'(last_gtype), 32'h4);
    chk("cold_rdata", rlog[$], 32'h22);

    // Back-to-back hits
    g0 = grants;
    issue(0, 20'h1fc00, 8'h00, 4'h0);
    issue(0, 20'h1fc00, 8'h00, 4'h8);
    issue(0, 20'h1fc00, 8'h00, 4'hc);
    drain();
    k = rlog.size();
    chk("b2b_rdata0", rlog[k-3], 32'h11);
    chk("b2b_rdata1", rlog[k-2], 32'h33);
    chk("b2b_rdata2", rlog[k-1], 32'h44);
    chk("b2b_spacing", 32'(dcyc[k-1] - dcyc[k-3]), 32'd2);
    chk("b2b_no_bus", 32'(grants - g0), 32'd0);

    // Uncached, then a cached access to the same index must miss
    issue(1, 20'h1fc00, 8'h01, 4'h8); drain();
    chk("unc_rd_addr", last_gaddr, 32'h1fc00018);
    chk("unc_rd_type", 32'(last_gtype), 32'h2);
    chk("unc_rdata", rlog[$], 32'hdeadbeef);
    g0 = grants;
    issue(0, 20'h1fc00, 8'h01, 4'h8); drain();
    chk("unc_then_miss", 32'(grants - g0), 32'd1);
    chk("unc_then_addr", last_gaddr, 32'h1fc00010);

    // Conflict eviction
    issue(0, 20'h00400, 8'h00, 4'h0); drain();
    chk("conf_rd_addr", last_gaddr, 32'h00400000);
    chk("conf_rdata", rlog[$], 32'ha0a00000);
    g0 = grants;
    issue(0, 20'h1fc00, 8'h00, 4'h4); drain();
    chk("conf_remiss", 32'(grants - g0), 32'd1);
    chk("conf_remiss_rdata", rlog[$], 32'h22);

    // Stall: request held through MISS with rd_rdy low for 5 cycles
    stall_n = 5;
    issue(0, 20'h00777, 8'h05, 4'h0);
    issue(0, 20'h00777, 8'h05, 4'h4);
    drain();
    k = dcyc.size();
    chk("stall_req_cycles", 32'(req_cycles), 32'd6);
    chk("stall_next_dok", 32'(dcyc[k-1] - dcyc[k-2]), 32'd2);
    stall_n = 0;

    // Reset in the middle of a refill
    g0 = grants;
    issue(0, 20'h00400, 8'h00, 4'hc);
    k = 0;
    while (!(grants > g0 && burst_beats >= 2)) begin
      @(posedge clk); #2;
      k++;
      if (k > 300) begin fail("mid_refill_wait"); break; end
    end
    resetn = 0;
    #1;
    chk("midrst_rd_req", 32'(bif.rd_req), 32'd0);
    chk("midrst_data_ok", 32'(bif.data_ok), 32'd0);
    repeat (2) @(posedge clk);
    #2 resetn = 1;
    @(posedge clk); #1;
    issue(0, 20'h00400, 8'h00, 4'hc); drain();
    chk("midrst_refetch", 32'(grants - g0), 32'd2);
    chk("midrst_rd_type", 32'(last_gtype), 32'h4);
    chk("midrst_beats", 32'(burst_beats), 32'd4);
    chk("midrst_rdata", rlog[$], 32'ha0a00003);

    // Randomized traffic
    rand_stall = 1;
    for (int r = 0; r < 400; r++) begin
      u = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       t = 20'h1fc00;
        1:       t = 20'h00400;
        2:       t = 20'h12345;
        default: t = 20'($urandom);
      endcase
      ix = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      o  = {2'($urandom_range(0, 3)), 2'b00};
      issue(u, t, ix, o);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
